// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end.
// Provides the fetch entry payload, the NOP encoding, the reset vector and a
// word-alignment helper.
package ifetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0 -- shown on the IF/ID side whenever nothing is valid
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_1000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;

  // Clear the two byte-offset bits of an address
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Prefetch queue of {pc, instruction} pairs.
// Ports:
//   i_clk, i_reset        clock, async active-high reset
//   i_push, i_push_data   write one entry at the tail
//   i_pop                 advance the head (ignored when empty)
//   i_flush               drop all entries; overrides push and pop
//   o_head                entry at the head (meaningful when o_count != 0)
//   o_count               number of stored entries, 0..DEPTH
module fetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic                     w_do_push;
  logic                     w_do_pop;

  // Flush wins over everything; full/empty guards keep the pointers coherent
  assign w_do_push = i_push & ~i_flush & (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop  & ~i_flush & (r_count != '0);

  // Storage: no reset needed, contents are qualified by r_count
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at a power-of-two depth
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end feeding the IF/ID register.
// Issues pipelined imem requests under a credit scheme so the prefetch queue
// never overflows, tags responses with their PC, and presents the queue head
// through a valid/ready handshake. A redirect flushes the queue, re-targets
// fetch, and arranges for in-flight responses to be discarded.
// Ports:
//   i_clk, i_reset                      clock, async active-high reset
//   i_redirect, i_redirect_pc           taken branch/jump target from EX
//   o_imem_req, o_imem_addr, i_imem_gnt imem request channel
//   i_imem_rvalid, i_imem_rdata         in-order imem response channel
//   o_valid, o_pc, o_instruction        queue head toward IF/ID
//   i_ready                             IF/ID accepts the head
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned     WIDTH           = XLEN,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [WIDTH-1:0] RESET_PC       = RESET_VECTOR
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_instruction,
  input  logic             i_ready
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  r_fetch_pc;
  logic [WIDTH-1:0]  r_resp_pc;
  logic [OUT_W-1:0]  r_outstanding;
  logic [OUT_W-1:0]  r_drop_cnt;

  logic [WIDTH-1:0]  w_fetch_pc_nxt;
  logic [WIDTH-1:0]  w_resp_pc_nxt;
  logic [OUT_W-1:0]  w_outstanding_nxt;
  logic [OUT_W-1:0]  w_drop_cnt_nxt;

  logic [WIDTH-1:0]  w_target;
  logic              w_out_ok;
  logic              w_credit_ok;
  logic              w_grant;
  logic              w_resp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;
  logic [CNT_W-1:0]  w_count;
  logic [1:0]        w_unused_pc_lsbs;

  assign w_target         = {i_redirect_pc[WIDTH-1:2], 2'b00};
  assign w_unused_pc_lsbs = i_redirect_pc[1:0];

  // Credit: queued entries plus answers still owed must fit in the queue
  assign w_out_ok    = 32'(r_outstanding) < MAX_OUTSTANDING;
  assign w_credit_ok = (32'(w_count) + 32'(r_outstanding)) < DEPTH;

  assign o_imem_req  = ~i_reset & ~i_redirect & w_out_ok & w_credit_ok;
  assign o_imem_addr = r_fetch_pc;

  // A response with nothing outstanding is a bus violation and is ignored
  assign w_grant = o_imem_req & i_imem_gnt;
  assign w_resp  = i_imem_rvalid & (r_outstanding != '0);
  assign w_drop  = w_resp & (r_drop_cnt != '0);
  assign w_push  = w_resp & ~w_drop & ~i_redirect;
  assign w_pop   = o_valid & i_ready;

  assign w_push_data.pc          = r_resp_pc;
  assign w_push_data.instruction = i_imem_rdata;

  // Next-state for the request/response bookkeeping
  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_resp_pc_nxt     = r_resp_pc;
    w_outstanding_nxt = r_outstanding;
    w_drop_cnt_nxt    = r_drop_cnt;

    case ({w_grant, w_resp})
      2'b10:   w_outstanding_nxt = r_outstanding + OUT_W'(1);
      2'b01:   w_outstanding_nxt = r_outstanding - OUT_W'(1);
      default: w_outstanding_nxt = r_outstanding;
    endcase

    if (i_redirect) begin
      // Everything still owed after this cycle belongs to the old stream
      w_fetch_pc_nxt = w_target;
      w_resp_pc_nxt  = w_target;
      w_drop_cnt_nxt = r_outstanding - OUT_W'(w_resp);
    end else begin
      if (w_grant) begin
        w_fetch_pc_nxt = r_fetch_pc + WIDTH'(4);
      end
      if (w_push) begin
        w_resp_pc_nxt = r_resp_pc + WIDTH'(4);
      end
      if (w_drop) begin
        w_drop_cnt_nxt = r_drop_cnt - OUT_W'(1);
      end
    end
  end

  // Bookkeeping registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (i_redirect),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // Head presentation; idle shows PC 0 and a NOP
  assign o_valid       = (w_count != '0);
  assign o_pc          = o_valid ? WIDTH'(w_head.pc) : '0;
  assign o_instruction = o_valid ? WIDTH'(w_head.instruction) : WIDTH'(NOP_INSTR);

endmodule
